mem_arb2: RTL and testbench
===========================

# mem_arb2

Two-to-one memory port arbiter for the RV32i core. Instruction fetch (port 0) and load/store unit (port 1) share a single data-memory port. The forward direction multiplexes requests onto the shared port. The return direction demultiplexes each in-order response back to the port that issued it, using an internal FIFO of requester IDs.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of write and read data.
- `ADDR_WIDTH`, 32: byte address width.
- `MAX_OUTSTANDING`, 2: ID FIFO depth. Must be a power of two, ≥ 2.

Ports. Clock is `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `m0_req_valid`, `m1_req_valid`  in  1  request present.
- `m0_req_ready`, `m1_req_ready`  out  1  request accepted this cycle.
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  byte address.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH  write data.
- `m0_be`, `m1_be`  in  DATA_WIDTH/8  byte enables.
- `m0_rsp_valid`, `m1_rsp_valid`  out  1  response for that port.
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH  read data. Both driven from `s_rdata`.
- `s_req_valid`  out  1  shared-port request.
- `s_req_ready`  in  1  shared-port accept.
- `s_addr`, `s_we`, `s_wdata`, `s_be`  out  as above  granted request fields.
- `s_rsp_valid`  in  1  shared-port response. Always in order; one per accepted request, reads and writes alike; no backpressure.
- `s_rdata`  in  DATA_WIDTH  response data.
- `rsp_err`  out  1  sticky protocol-error flag.

## Operation
- **Transfer definition:** a transfer occurs when `s_req_valid && s_req_ready`.
- **Grant:** `grant` is 0 or 1. The `s_*` request fields come from `m[grant]`.
- **Request valid:** `s_req_valid = (m0_req_valid | m1_req_valid) && !fifo_full && !rst`.
- **Request ready:** `m[k]_req_ready = s_req_valid && s_req_ready && grant == k`. The non-granted port sees ready = 0.
- **Arbitration:** with one requester, that port is granted. With both requesting, the default is fixed priority: port 1 (LSU) wins.
- **Grant lock:** if `s_req_valid` is high and `s_req_ready` is low, the `locked` bit sets and `grant` is held until the transfer completes. A newly arriving higher-priority request does not preempt it. `locked` clears on the transfer.
- **ID FIFO push:** each transfer pushes `grant` into the ID FIFO.
- **Response routing:** on `s_rsp_valid` with the FIFO non-empty:
  - pop the head;
  - assert `m[head]_rsp_valid` combinationally in the same cycle;
  - the other port's `rsp_valid` stays 0.
- **Response while empty:** if `s_rsp_valid` arrives with the FIFO empty, there is no pop, no `rsp_valid`, and `rsp_err` sets. `rsp_err` stays set until reset.
- **Full FIFO:** when the FIFO is full, `s_req_valid` is 0, even if a pop happens in the same cycle. Requests resume the cycle after the pop.
- **Simultaneous push and pop** when non-empty and not full: both happen; occupancy is unchanged.
- **Push and response in the same cycle while empty:** the response is an error per the empty-FIFO rule. Responses must come at least one cycle after their transfer.
- **Occupancy counter:** `$clog2(MAX_OUTSTANDING)+1` bits. Read and write pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- **Reset values:**
  - FIFO empty, pointers 0, count 0;
  - `locked` = 0, `rsp_err` = 0, round-robin `last_grant` = 1;
  - all ready and rsp_valid outputs 0;
  - `s_req_valid` = 0 while `rst` is high.
- **Reset mid-operation:** all outstanding IDs are discarded.
- **Request path:** combinational, zero added latency.
- **Response path:** combinational from `s_rsp_valid` and the FIFO head, zero latency.
- **Sequential state:** FIFO storage and pointers, count, `locked`, `last_grant`, `rsp_err`.
- **Throughput:** one transfer per cycle sustained while the FIFO is not full.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin arbitration. When both ports request and the grant is not locked, the port other than `last_grant` wins. `last_grant` updates on every transfer.
- **`MEM_ARB_RR_EN` undefined:** fixed priority, port 1 over port 0. `last_grant` is not implemented.

## Structure
- **Shared package / `src/defines.vh`:**
  - port ID constants `MEM_PORT_IF` = 0, `MEM_PORT_LSU` = 1;
  - the default `MEM_ARB_MAX_OUTSTANDING`.
- **Sub-module `id_fifo`:** parameterised width and depth, push/pop/full/empty/count, async active-high reset. It is instantiated with width 1.
- **Top-level logic:** grant and lock logic, plus the response demultiplexer.

## Test plan
- **Single read:** m0 reads `0x0000_0100`, slave accepts immediately and responds 2 cycles later with `0xDEADBEEF` → `m0_req_ready` pulses 1 cycle; `m0_rsp_valid` = 1 with `m0_rdata` = `0xDEADBEEF`; `m1_rsp_valid` stays 0.
- **Contention:** m0 and m1 both valid in cycle 0, `s_req_ready` = 1.
  - Fixed priority: m1 is granted first (`s_addr` = m1 addr), m0 in cycle 1. The two responses route to m1 then m0.
  - With `MEM_ARB_RR_EN`, after reset m0 wins first (`last_grant` = 1), then m1.
- **Lock:** m0 is valid and granted with `s_req_ready` = 0 for 3 cycles; m1 asserts in cycle 1 → `s_addr` stays m0's for all cycles; m0 transfers first, then m1.
- **Full:** `MAX_OUTSTANDING` = 2. Two m1 writes are accepted with no response → `s_req_valid` = 0 and m0 is stalled. One response arrives → `m1_rsp_valid` = 1, and the next cycle `s_req_valid` = 1.
- **Protocol error:** `s_rsp_valid` pulses with the FIFO empty → no rsp_valid on either port; `rsp_err` = 1 and stays 1 until `rst`.
- **Reset mid-operation:** 1 outstanding ID, then `rst` pulses asynchronously mid-cycle → count 0, `rsp_err` 0; a following `s_rsp_valid` sets `rsp_err`.

Source files
------------

// File: rtl/mem_arb2_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb2_pkg
// Shared definitions for the two-to-one memory port arbiter.
//   - Port ID constants used as grant values and as the ID FIFO payload.
//   - Default depth of the outstanding-request ID FIFO.
//   - Lock state type for the grant hold logic.
//   - Fixed-priority grant helper (LSU wins whenever it requests).
// -----------------------------------------------------------------------------
package mem_arb2_pkg;

    // Requester IDs: the grant value and the ID stored per outstanding request.
    localparam logic MEM_PORT_IF  = 1'b0;   // instruction fetch
    localparam logic MEM_PORT_LSU = 1'b1;   // load/store unit

    // Default number of requests that may be in flight on the shared port.
    localparam int MEM_ARB_MAX_OUTSTANDING = 2;

    // ARB_LOCKED: a request has been offered but not yet accepted, so the
    // grant must be held until the transfer completes.
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Fixed priority: the LSU is granted whenever it requests, otherwise the
    // instruction fetch port.
    function automatic logic fixed_grant(input logic lsu_valid);
        return lsu_valid ? MEM_PORT_LSU : MEM_PORT_IF;
    endfunction

endpackage

// File: rtl/mem_arb2_id_fifo.sv
// -----------------------------------------------------------------------------
// mem_arb2_id_fifo
// Small synchronous FIFO holding the requester ID of every request that has
// been accepted by the shared port but not yet answered.
//
// Parameters:
//   WIDTH  payload width (the arbiter uses 1)
//   DEPTH  number of entries, power of two, >= 2
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset (empties the FIFO)
//   push       write push_data (ignored when full)
//   push_data  payload to store
//   pop        discard the head entry (ignored when empty)
//   pop_data   current head entry, valid while !empty
//   full       DEPTH entries held
//   empty      no entries held
//   count      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mem_arb2_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Head is read combinationally: the response must be routed in the same
    // cycle it arrives.
    assign pop_data = mem[rd_ptr_reg];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mem_arb2.sv
// -----------------------------------------------------------------------------
// mem_arb2
// Two-to-one memory port arbiter. Port 0 (instruction fetch) and port 1
// (load/store unit) share one data-memory port. Requests are multiplexed onto
// the shared port combinationally; in-order responses are steered back to the
// issuing port using a FIFO of requester IDs.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin when both ports request
//                  undefined -> fixed priority, LSU (port 1) over IF (port 0)
//
// Parameters:
//   DATA_WIDTH       read/write data width
//   ADDR_WIDTH       byte address width
//   MAX_OUTSTANDING  ID FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   m0_* / m1_*                   requester ports: req_valid/req_ready,
//                                 addr, we, wdata, be, rsp_valid, rdata
//   s_req_valid / s_req_ready     shared-port request handshake
//   s_addr, s_we, s_wdata, s_be   granted request fields
//   s_rsp_valid, s_rdata          shared-port in-order response
//   rsp_err                       sticky: response arrived with nothing
//                                 outstanding
// -----------------------------------------------------------------------------
module mem_arb2
    import mem_arb2_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    output logic                    m0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    output logic                    m1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic                    s_req_valid,
    input  logic                    s_req_ready,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic                    s_we,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_be,
    input  logic                    s_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   s_rdata,

    output logic                    rsp_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e        arb_state_reg;
    logic              held_grant_reg;
    logic              rsp_err_reg;
    logic              grant;
    logic              xfer;
    logic              rsp_pop;

    logic              fifo_full;
    logic              fifo_empty;
    logic [0:0]        fifo_head;
    logic [CNT_W-1:0]  fifo_count;

`ifdef MEM_ARB_RR_EN
    logic              last_grant_reg;
`endif

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        grant = MEM_PORT_IF;
        if (arb_state_reg == ARB_LOCKED) begin
            // An offered request is never withdrawn in favour of another.
            grant = held_grant_reg;
        end else if (m0_req_valid && m1_req_valid) begin
`ifdef MEM_ARB_RR_EN
            grant = ~last_grant_reg;
`else
            grant = fixed_grant(1'b1);
`endif
        end else begin
            grant = fixed_grant(m1_req_valid);
        end
    end

    // ------------------------------------------------------------------
    // Forward path
    // ------------------------------------------------------------------
    // A full ID FIFO blocks requests even if a pop occurs this cycle; the
    // freed slot becomes usable on the following cycle.
    assign s_req_valid = (m0_req_valid | m1_req_valid) && !fifo_full && !rst;
    assign xfer        = s_req_valid && s_req_ready;

    assign s_addr  = (grant == MEM_PORT_LSU) ? m1_addr  : m0_addr;
    assign s_we    = (grant == MEM_PORT_LSU) ? m1_we    : m0_we;
    assign s_wdata = (grant == MEM_PORT_LSU) ? m1_wdata : m0_wdata;
    assign s_be    = (grant == MEM_PORT_LSU) ? m1_be    : m0_be;

    assign m0_req_ready = xfer && (grant == MEM_PORT_IF);
    assign m1_req_ready = xfer && (grant == MEM_PORT_LSU);

    // ------------------------------------------------------------------
    // Outstanding requester IDs
    // ------------------------------------------------------------------
    mem_arb2_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer),
        .push_data (grant),
        .pop       (rsp_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ------------------------------------------------------------------
    // Return path
    // ------------------------------------------------------------------
    // A response in the same cycle as the first push still sees an empty
    // FIFO and is treated as unsolicited.
    assign rsp_pop      = s_rsp_valid && !fifo_empty;
    assign m0_rsp_valid = rsp_pop && (fifo_head == MEM_PORT_IF);
    assign m1_rsp_valid = rsp_pop && (fifo_head == MEM_PORT_LSU);
    assign m0_rdata     = s_rdata;
    assign m1_rdata     = s_rdata;
    assign rsp_err      = rsp_err_reg;

    // ------------------------------------------------------------------
    // Lock state, error flag and round-robin history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state_reg  <= ARB_OPEN;
            held_grant_reg <= MEM_PORT_IF;
            rsp_err_reg    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_reg <= MEM_PORT_LSU;
`endif
        end else begin
            case (arb_state_reg)
                ARB_OPEN: begin
                    if (s_req_valid && !s_req_ready) begin
                        arb_state_reg  <= ARB_LOCKED;
                        held_grant_reg <= grant;
                    end
                end
                ARB_LOCKED: begin
                    if (xfer) begin
                        arb_state_reg <= ARB_OPEN;
                    end
                end
                default: arb_state_reg <= ARB_OPEN;
            endcase

            if (s_rsp_valid && (fifo_count == '0)) begin
                rsp_err_reg <= 1'b1;
            end

`ifdef MEM_ARB_RR_EN
            if (xfer) begin
                last_grant_reg <= grant;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_arb2.sv
module tb_mem_arb2;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m1_req_valid;
    logic        m0_req_ready, m1_req_ready;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_we, m1_we;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_rsp_valid, m1_rsp_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req_valid, s_req_ready;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic        s_rsp_valid;
    logic [31:0] s_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];
    int first;

    mem_arb2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_be(s_be),
        .s_rsp_valid(s_rsp_valid), .s_rdata(s_rdata),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Drive one shared-port response and check routing against the scoreboard.
    task automatic rsp_check(input logic [31:0] data);
        int p;
        s_rsp_valid = 1'b1;
        s_rdata     = data;
        settle();
        if (exp_q.size() == 0) begin
            chk("rsp_none_m0", 32'(m0_rsp_valid), 32'd0);
            chk("rsp_none_m1", 32'(m1_rsp_valid), 32'd0);
            $display("rsp data=%h expected no port, m0v=%0b m1v=%0b", data, m0_rsp_valid, m1_rsp_valid);
        end else begin
            p = exp_q.pop_front();
            chk("rsp_m0_valid", 32'(m0_rsp_valid), 32'(p == 0));
            chk("rsp_m1_valid", 32'(m1_rsp_valid), 32'(p == 1));
            chk("rsp_rdata", (p == 1) ? m1_rdata : m0_rdata, data);
            $display("rsp data=%h expected port %0d, m0v=%0b m1v=%0b", data, p, m0_rsp_valid, m1_rsp_valid);
        end
    endtask

    task automatic rsp(input logic [31:0] data);
        rsp_check(data);
        tick();
        s_rsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_req_valid = 1'b1; m1_req_valid = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_we = 1'b0; m1_we = 1'b0;
        m0_wdata = '0; m1_wdata = '0; m0_be = 4'hF; m1_be = 4'hF;
        s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rdata = '0;

        // ---- reset state (request present while rst is high) ----
        #3;
        chk("rst_s_req_valid", 32'(s_req_valid), 32'd0);
        chk("rst_m0_ready", 32'(m0_req_ready), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_m0_rsp_valid", 32'(m0_rsp_valid), 32'd0);
        chk("rst_count", 32'(dut.fifo_count), 32'd0);
        $display("reset: s_req_valid=%0b rsp_err=%0b", s_req_valid, rsp_err);
        m0_req_valid = 1'b0;
        tick();
        rst = 1'b0;

        // ---- contention ----
`ifdef MEM_ARB_RR_EN
        first = 0;
`else
        first = 1;
`endif
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_req_ready = 1'b1;
        settle();
        chk("cont0_s_req_valid", 32'(s_req_valid), 32'd1);
        chk("cont0_s_addr", s_addr, (first == 1) ? 32'h0000_2000 : 32'h0000_1000);
        chk("cont0_m0_ready", 32'(m0_req_ready), 32'(first == 0));
        chk("cont0_m1_ready", 32'(m1_req_ready), 32'(first == 1));
        $display("contention c0: s_addr=%h expected port %0d", s_addr, first);
        exp_q.push_back(first);
        tick();
        if (first == 1) m1_req_valid = 1'b0; else m0_req_valid = 1'b0;
        settle();
        chk("cont1_s_addr", s_addr, (first == 1) ? 32'h0000_1000 : 32'h0000_2000);
        chk("cont1_m0_ready", 32'(m0_req_ready), 32'(first == 1));
        chk("cont1_m1_ready", 32'(m1_req_ready), 32'(first == 0));
        $display("contention c1: s_addr=%h expected port %0d", s_addr, 1 - first);
        exp_q.push_back(1 - first);
        tick();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        tick();
        rsp(32'h1111_1111);
        rsp(32'h2222_2222);

        // ---- single read ----
        m0_addr = 32'h0000_0100; m0_we = 1'b0; m0_req_valid = 1'b1;
        settle();
        chk("single_m0_ready", 32'(m0_req_ready), 32'd1);
        chk("single_m1_ready", 32'(m1_req_ready), 32'd0);
        chk("single_s_addr", s_addr, 32'h0000_0100);
        chk("single_s_we", 32'(s_we), 32'd0);
        $display("single read: s_addr=%h m0_ready=%0b", s_addr, m0_req_ready);
        exp_q.push_back(0);
        tick();
        m0_req_valid = 1'b0;
        settle();
        chk("single_ready_pulse", 32'(m0_req_ready), 32'd0);
        tick();
        rsp(32'hDEAD_BEEF);

        // ---- lock ----
        s_req_ready = 1'b0;
        m0_addr = 32'h0000_0200; m0_req_valid = 1'b1;
        m1_addr = 32'h0000_0300;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) m1_req_valid = 1'b1;
            settle();
            chk("lock_s_addr", s_addr, 32'h0000_0200);
            chk("lock_m1_ready", 32'(m1_req_ready), 32'd0);
            chk("lock_s_req_valid", 32'(s_req_valid), 32'd1);
            $display("lock c%0d: s_addr=%h", c, s_addr);
            tick();
        end
        s_req_ready = 1'b1;
        settle();
        chk("lock_xfer_s_addr", s_addr, 32'h0000_0200);
        chk("lock_xfer_m0_ready", 32'(m0_req_ready), 32'd1);
        chk("lock_xfer_m1_ready", 32'(m1_req_ready), 32'd0);
        $display("lock release: s_addr=%h m0_ready=%0b", s_addr, m0_req_ready);
        exp_q.push_back(0);
        tick();
        m0_req_valid = 1'b0;
        settle();
        chk("lock_next_s_addr", s_addr, 32'h0000_0300);
        chk("lock_next_m1_ready", 32'(m1_req_ready), 32'd1);
        $display("after lock: s_addr=%h m1_ready=%0b", s_addr, m1_req_ready);
        exp_q.push_back(1);
        tick();
        m1_req_valid = 1'b0;
        rsp(32'h3333_3333);
        rsp(32'h4444_4444);

        // ---- full ----
        m1_we = 1'b1; m1_be = 4'h3;
        for (int w = 0; w < 2; w++) begin
            m1_addr = 32'h0000_0400 + 32'(w * 4);
            m1_wdata = 32'hCAFE_0000 + 32'(w);
            m1_req_valid = 1'b1;
            settle();
            chk("full_wr_m1_ready", 32'(m1_req_ready), 32'd1);
            chk("full_wr_s_we", 32'(s_we), 32'd1);
            chk("full_wr_s_wdata", s_wdata, 32'hCAFE_0000 + 32'(w));
            chk("full_wr_s_be", 32'(s_be), 32'h3);
            $display("full write %0d: s_addr=%h s_wdata=%h", w, s_addr, s_wdata);
            exp_q.push_back(1);
            tick();
        end
        m1_req_valid = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0000_0500; m0_req_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("full_s_req_valid", 32'(s_req_valid), 32'd0);
            chk("full_m0_ready", 32'(m0_req_ready), 32'd0);
            $display("full stall c%0d: s_req_valid=%0b", c, s_req_valid);
            tick();
        end
        rsp_check(32'h5555_0000);
        chk("full_pop_s_req_valid", 32'(s_req_valid), 32'd0);
        tick();
        s_rsp_valid = 1'b0;
        settle();
        chk("full_resume_s_req_valid", 32'(s_req_valid), 32'd1);
        chk("full_resume_m0_ready", 32'(m0_req_ready), 32'd1);
        chk("full_resume_s_addr", s_addr, 32'h0000_0500);
        $display("full resume: s_req_valid=%0b s_addr=%h", s_req_valid, s_addr);
        exp_q.push_back(0);
        tick();
        m0_req_valid = 1'b0;
        rsp(32'h6666_6666);
        rsp(32'h7777_7777);

        // ---- protocol error ----
        settle();
        chk("err_before", 32'(rsp_err), 32'd0);
        rsp(32'hBAD0_BAD0);
        settle();
        chk("err_set", 32'(rsp_err), 32'd1);
        tick();
        tick();
        chk("err_sticky", 32'(rsp_err), 32'd1);
        $display("protocol error: rsp_err=%0b", rsp_err);

        // ---- reset mid-operation ----
        m0_addr = 32'h0000_0600; m0_req_valid = 1'b1;
        settle();
        chk("rmo_m0_ready", 32'(m0_req_ready), 32'd1);
        tick();
        m0_req_valid = 1'b0;
        settle();
        chk("rmo_count_before", 32'(dut.fifo_count), 32'd1);
        #1;
        rst = 1'b1;
        m1_req_valid = 1'b1;
        #1;
        chk("rmo_count", 32'(dut.fifo_count), 32'd0);
        chk("rmo_rsp_err", 32'(rsp_err), 32'd0);
        chk("rmo_s_req_valid", 32'(s_req_valid), 32'd0);
        $display("reset mid-op: count=%0d rsp_err=%0b", dut.fifo_count, rsp_err);
        exp_q.delete();
        #2;
        rst = 1'b0;
        m1_req_valid = 1'b0;
        tick();
        rsp(32'h5A5A_5A5A);
        settle();
        chk("rmo_err_after", 32'(rsp_err), 32'd1);
        $display("post-reset response: rsp_err=%0b", rsp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
